m_wb_arbiter2: RTL

M_WB_ARBITER2 -- requirements
Module: m_wb_arbiter2

---
 rtl/m_wb_pkg.sv | 16 +
 rtl/m_wb_arbiter2_if.sv | 54 +++++
 rtl/m_wb_timeout.sv | 33 +++
 rtl/m_wb_arbiter2.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/m_wb_pkg.sv
// m_wb_pkg -- shared definitions for the two-master Wishbone arbiter.
//   state_t          : arbiter FSM encoding (IDLE / GNT0 / GNT1)
//   TIMEOUT_DEFAULT  : default watchdog limit in un-ACKed strobe cycles
//   CNT_W            : watchdog counter width (covers TIMEOUT range 2..255)
package m_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/m_wb_arbiter2_if.sv
// m_wb_arbiter2_if -- bundle of all Wishbone signals around the arbiter:
// two upstream masters (m0_*, m1_*), broadcast read data (m_DAT_O) and the
// shared downstream slave bus (s_*).
//   modport slave  : arbiter view (takes master requests, drives slave bus)
//   modport master : environment view (drives masters and slave responses)
//
// Handshake: a master requests by holding CYC and STB high with ADR/DAT/SEL/WE
// stable; the transfer completes in the cycle where ACK (or ERR) is high, and
// the master may change STB/ADR only after that cycle. CYC held high across
// several transfers keeps the grant (bus lock).
interface m_wb_arbiter2_if #(
  parameter int ADRWIDTH = 32
);
  logic                m0_CYC_I, m0_STB_I, m0_WE_I;
  logic [ADRWIDTH-1:0] m0_ADR_I;
  logic [31:0]         m0_DAT_I;
  logic [3:0]          m0_SEL_I;
  logic                m0_ACK_O, m0_ERR_O;

  logic                m1_CYC_I, m1_STB_I, m1_WE_I;
  logic [ADRWIDTH-1:0] m1_ADR_I;
  logic [31:0]         m1_DAT_I;
  logic [3:0]          m1_SEL_I;
  logic                m1_ACK_O, m1_ERR_O;

  logic [31:0]         m_DAT_O;

  logic                s_CYC_O, s_STB_O, s_WE_O;
  logic [ADRWIDTH-1:0] s_ADR_O;
  logic [31:0]         s_DAT_O;
  logic [3:0]          s_SEL_O;
  logic [31:0]         s_DAT_I;
  logic                s_ACK_I;

  modport slave (
    input  m0_CYC_I, m0_STB_I, m0_WE_I, m0_ADR_I, m0_DAT_I, m0_SEL_I,
    output m0_ACK_O, m0_ERR_O,
    input  m1_CYC_I, m1_STB_I, m1_WE_I, m1_ADR_I, m1_DAT_I, m1_SEL_I,
    output m1_ACK_O, m1_ERR_O,
    output m_DAT_O,
    output s_CYC_O, s_STB_O, s_WE_O, s_ADR_O, s_DAT_O, s_SEL_O,
    input  s_DAT_I, s_ACK_I
  );

  modport master (
    output m0_CYC_I, m0_STB_I, m0_WE_I, m0_ADR_I, m0_DAT_I, m0_SEL_I,
    input  m0_ACK_O, m0_ERR_O,
    output m1_CYC_I, m1_STB_I, m1_WE_I, m1_ADR_I, m1_DAT_I, m1_SEL_I,
    input  m1_ACK_O, m1_ERR_O,
    input  m_DAT_O,
    input  s_CYC_O, s_STB_O, s_WE_O, s_ADR_O, s_DAT_O, s_SEL_O,
    output s_DAT_I, s_ACK_I
  );
endinterface

// File: rtl/m_wb_timeout.sv
// m_wb_timeout -- bus watchdog. Counts consecutive cycles with the slave
// strobe high and no acknowledge; raises hit once the count equals TIMEOUT.
//   clk, rst : clock, synchronous active-high reset
//   stb      : slave strobe as seen on the bus
//   ack      : slave acknowledge
//   clr      : grant is changing this cycle (restart the count)
//   hit      : count has reached TIMEOUT (registered count, no comb path)
module m_wb_timeout
  import m_wb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  input  logic clr,
  output logic hit
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || ack) begin
      cnt <= '0;
    end else if (stb) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt == LIMIT);
endmodule

// File: rtl/m_wb_arbiter2.sv
// m_wb_arbiter2 -- two-master Wishbone arbiter onto a shared slave bus.
// Round-robin on simultaneous requests, no preemption while CYC is held.
// Slave-side outputs are a mux of the granted master selected by the state
// register, so the bus follows the grant one cycle after the request.
//   CLK_I     : clock, all state on rising edge
//   RST_I     : synchronous active-high reset
//   bus       : m_wb_arbiter2_if.slave (m0_*, m1_*, m_DAT_O, s_*)
//   dbg_state : current FSM state
// Optional feature: define WB_ARB_TIMEOUT_EN to build in the watchdog that
// aborts a granted cycle with ERR after TIMEOUT un-ACKed strobe cycles.
module m_wb_arbiter2
  import m_wb_pkg::*;
#(
  parameter int ADRWIDTH = 32,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  m_wb_arbiter2_if.slave    bus,
  output state_t            dbg_state
);
  state_t              state;
  logic                last_gnt;  // 1: master 1 was granted last
  logic                hit;

  logic                cyc_g, stb_g, we_g;
  logic [ADRWIDTH-1:0] adr_g;
  logic [31:0]         dat_g;
  logic [3:0]          sel_g;
  logic                stb_out;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state    <= IDLE;
      last_gnt <= 1'b1;  // master 0 wins the first tie
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.m0_CYC_I && (!bus.m1_CYC_I || last_gnt)) begin
            state    <= GNT0;
            last_gnt <= 1'b0;
          end else if (bus.m1_CYC_I) begin
            state    <= GNT1;
            last_gnt <= 1'b1;
          end
        end
        GNT0: begin
          if (hit) begin
            state <= IDLE;
          end else if (!bus.m0_CYC_I) begin
            if (bus.m1_CYC_I) begin
              state    <= GNT1;
              last_gnt <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        GNT1: begin
          if (hit) begin
            state <= IDLE;
          end else if (!bus.m1_CYC_I) begin
            if (bus.m0_CYC_I) begin
              state    <= GNT0;
              last_gnt <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

  always_comb begin
    cyc_g = 1'b0;
    stb_g = 1'b0;
    we_g  = 1'b0;
    adr_g = '0;
    dat_g = '0;
    sel_g = '0;
    unique case (state)
      GNT0: begin
        cyc_g = bus.m0_CYC_I;
        stb_g = bus.m0_STB_I;
        we_g  = bus.m0_WE_I;
        adr_g = bus.m0_ADR_I;
        dat_g = bus.m0_DAT_I;
        sel_g = bus.m0_SEL_I;
      end
      GNT1: begin
        cyc_g = bus.m1_CYC_I;
        stb_g = bus.m1_STB_I;
        we_g  = bus.m1_WE_I;
        adr_g = bus.m1_ADR_I;
        dat_g = bus.m1_DAT_I;
        sel_g = bus.m1_SEL_I;
      end
      default: ;
    endcase
  end

  // The abort cycle keeps CYC but withdraws STB so the slave sees no new request.
  assign stb_out     = stb_g & cyc_g & ~hit;

  assign bus.s_CYC_O = cyc_g;
  assign bus.s_STB_O = stb_out;
  assign bus.s_WE_O  = we_g;
  assign bus.s_ADR_O = adr_g;
  assign bus.s_DAT_O = dat_g;
  assign bus.s_SEL_O = sel_g;
  assign bus.m_DAT_O = bus.s_DAT_I;

  assign bus.m0_ACK_O = (state == GNT0) & bus.s_ACK_I & ~hit;
  assign bus.m1_ACK_O = (state == GNT1) & bus.s_ACK_I & ~hit;
  assign bus.m0_ERR_O = (state == GNT0) & hit;
  assign bus.m1_ERR_O = (state == GNT1) & hit;

`ifdef WB_ARB_TIMEOUT_EN
  logic grant_change;

  // Any cycle that ends with a different (or no) grant restarts the watchdog.
  assign grant_change = (state == IDLE)
                      | ((state == GNT0) & ~bus.m0_CYC_I)
                      | ((state == GNT1) & ~bus.m1_CYC_I)
                      | hit;

  m_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk (CLK_I),
    .rst (RST_I),
    .stb (stb_out),
    .ack (bus.s_ACK_I),
    .clr (grant_change),
    .hit (hit)
  );
`else
  assign hit = 1'b0;
`endif
endmodule
